spatz_spm_responder: RTL and testbench



---
 rtl/spatz_spm_pkg.sv | 39 +++
 rtl/spatz_spm_amo_alu.sv | 29 ++
 rtl/spatz_spm_responder.sv | 204 ++++++++++++++++++++
 tb/tb_spatz_spm_responder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spatz_spm_pkg.sv
// Shared types for the Spatz SPM responder: AMO opcodes, latency-pipe entry, FSM states.
// The AMO read-modify-write path is compiled in when SPATZ_SPM_AMO_EN is defined.
package spatz_spm_pkg;

    typedef enum logic [3:0] {
        AmoNone = 4'd0,
        AmoSwap = 4'd1,
        AmoAdd  = 4'd2,
        AmoAnd  = 4'd3,
        AmoOr   = 4'd4,
        AmoXor  = 4'd5,
        AmoMax  = 4'd6,
        AmoMaxu = 4'd7,
        AmoMin  = 4'd8,
        AmoMinu = 4'd9,
        AmoLR   = 4'd10,
        AmoSC   = 4'd11
    } amo_op_e;

    // Per-request bookkeeping carried alongside the SRAM access.
    typedef struct packed {
        logic valid;
        logic write;
        logic error;
        logic amo;
    } pipe_entry_t;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StAmoWait  = 2'd1,
        StAmoWrite = 2'd2
    } rsp_state_e;

    function automatic logic amo_is_rmw(input amo_op_e op);
        return op inside {AmoSwap, AmoAdd, AmoAnd, AmoOr, AmoXor,
                          AmoMax, AmoMaxu, AmoMin, AmoMinu};
    endfunction

endpackage

// File: rtl/spatz_spm_amo_alu.sv
// Combinational AMO datapath: computes the value written back for a read-modify-write.
module spatz_spm_amo_alu
    import spatz_spm_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  amo_op_e              op,
    input  logic [DataWidth-1:0] old_value,
    input  logic [DataWidth-1:0] operand,
    output logic [DataWidth-1:0] result_c
);

    always_comb begin
        result_c = old_value;
        case (op)
            AmoSwap: result_c = operand;
            AmoAdd:  result_c = old_value + operand;
            AmoAnd:  result_c = old_value & operand;
            AmoOr:   result_c = old_value | operand;
            AmoXor:  result_c = old_value ^ operand;
            AmoMax:  result_c = ($signed(old_value) > $signed(operand)) ? old_value : operand;
            AmoMaxu: result_c = (old_value > operand) ? old_value : operand;
            AmoMin:  result_c = ($signed(old_value) < $signed(operand)) ? old_value : operand;
            AmoMinu: result_c = (old_value < operand) ? old_value : operand;
            default: result_c = old_value;
        endcase
    end

endmodule

// File: rtl/spatz_spm_responder.sv
// SPM port responder: drives one SRAM bank and returns one in-order response per request.
// Define SPATZ_SPM_AMO_EN to enable the AMO read-modify-write path; otherwise AMOs return errors.
module spatz_spm_responder
    import spatz_spm_pkg::*;
#(
    parameter int unsigned AddrWidth    = 16,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned UserWidth    = 8,
    parameter int unsigned SramLatency  = 1,
    parameter int unsigned RspFifoDepth = 2
) (
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic                                             q_valid_i,
    output logic                                             q_ready_o,
    input  logic [AddrWidth-1:0]                             q_addr_i,
    input  logic                                             q_write_i,
    input  logic [3:0]                                       q_amo_i,
    input  logic [DataWidth-1:0]                             q_data_i,
    input  logic [DataWidth/8-1:0]                           q_strb_i,
    input  logic [UserWidth-1:0]                             q_user_i,
    output logic                                             p_valid_o,
    input  logic                                             p_ready_i,
    output logic [DataWidth-1:0]                             p_data_o,
    output logic [UserWidth-1:0]                             p_user_o,
    output logic                                             p_error_o,
    output logic                                             sram_req_o,
    output logic                                             sram_we_o,
    output logic [AddrWidth-$clog2(DataWidth/8)-1:0]         sram_addr_o,
    output logic [DataWidth-1:0]                             sram_wdata_o,
    output logic [DataWidth/8-1:0]                           sram_be_o,
    input  logic [DataWidth-1:0]                             sram_rdata_i
);

    localparam int unsigned StrbWidth  = DataWidth / 8;
    localparam int unsigned ByteOffset = $clog2(StrbWidth);
    localparam int unsigned WordWidth  = AddrWidth - ByteOffset;
    localparam int unsigned CntWidth   = $clog2(RspFifoDepth + 1);
    localparam int unsigned PtrWidth   = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
`ifdef SPATZ_SPM_AMO_EN
    localparam bit AmoEn = 1'b1;
`else
    localparam bit AmoEn = 1'b0;
`endif

    rsp_state_e           state_q, state_d;
    pipe_entry_t          pipe_q [SramLatency];
    logic [UserWidth-1:0] pipe_user_q [SramLatency];
    pipe_entry_t          pipe_in, exit_e;

    logic [DataWidth-1:0] fifo_data_q [RspFifoDepth];
    logic [UserWidth-1:0] fifo_user_q [RspFifoDepth];
    logic                 fifo_err_q  [RspFifoDepth];
    logic [CntWidth-1:0]  fifo_cnt_q, outstanding_q;
    logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;

    amo_op_e              q_op, amo_op_q;
    logic [DataWidth-1:0] amo_operand_q, amo_old_q, amo_result;
    logic [StrbWidth-1:0] amo_strb_q;
    logic [WordWidth-1:0] amo_addr_q;

    logic                 accept, rmw, push, pop, store, fifo_pop, amo_exit;
    logic [DataWidth-1:0] push_data;
    logic                 addr_unused;

    // Sub-word address bits select nothing in a word-wide bank.
    assign addr_unused = ^q_addr_i[ByteOffset-1:0];

    assign q_op      = amo_op_e'(q_amo_i);
    assign rmw       = AmoEn && amo_is_rmw(q_op);
    assign q_ready_o = !rst_i && (state_q == StIdle) &&
                       (outstanding_q < CntWidth'(RspFifoDepth));
    assign accept    = q_valid_i && q_ready_o;

    assign exit_e    = pipe_q[SramLatency-1];
    assign amo_exit  = (state_q == StAmoWait) && exit_e.valid && exit_e.amo;
    assign push      = exit_e.valid && !rst_i;
    assign push_data = (exit_e.write || exit_e.error) ? '0 : sram_rdata_i;

    // Fall-through response FIFO: an empty FIFO presents the exiting pipe entry directly.
    assign p_valid_o = !rst_i && ((fifo_cnt_q != '0) || push);
    assign p_data_o  = (fifo_cnt_q == '0) ? push_data                   : fifo_data_q[rd_ptr_q];
    assign p_user_o  = (fifo_cnt_q == '0) ? pipe_user_q[SramLatency-1] : fifo_user_q[rd_ptr_q];
    assign p_error_o = (fifo_cnt_q == '0) ? exit_e.error                : fifo_err_q[rd_ptr_q];
    assign pop       = p_valid_o && p_ready_i;
    assign fifo_pop  = pop && (fifo_cnt_q != '0);
    assign store     = push && !(pop && (fifo_cnt_q == '0));

    spatz_spm_amo_alu #(
        .DataWidth (DataWidth)
    ) i_amo_alu (
        .op        (amo_op_q),
        .old_value (amo_old_q),
        .operand   (amo_operand_q),
        .result_c  (amo_result)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        pipe_in      = '0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = q_addr_i[AddrWidth-1:ByteOffset];
        sram_wdata_o = q_data_i;
        sram_be_o    = q_strb_i;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    pipe_in.valid = 1'b1;
                    if (q_op == AmoNone) begin
                        sram_req_o    = 1'b1;
                        sram_we_o     = q_write_i;
                        pipe_in.write = q_write_i;
                    end else if (rmw) begin
                        sram_req_o  = 1'b1;
                        pipe_in.amo = 1'b1;
                        state_d     = StAmoWait;
                    end else begin
                        pipe_in.error = 1'b1;
                    end
                end
            end
            StAmoWait: begin
                if (amo_exit) state_d = StAmoWrite;
            end
            StAmoWrite: begin
                sram_req_o   = !rst_i;
                sram_we_o    = 1'b1;
                sram_addr_o  = amo_addr_q;
                sram_wdata_o = amo_result;
                sram_be_o    = amo_strb_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // AMO context: operands captured at accept, old value captured when the read returns.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            amo_op_q      <= AmoNone;
            amo_operand_q <= '0;
            amo_strb_q    <= '0;
            amo_addr_q    <= '0;
            amo_old_q     <= '0;
        end else begin
            if (accept && rmw) begin
                amo_op_q      <= q_op;
                amo_operand_q <= q_data_i;
                amo_strb_q    <= q_strb_i;
                amo_addr_q    <= q_addr_i[AddrWidth-1:ByteOffset];
            end
            if (amo_exit) amo_old_q <= sram_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SramLatency; i++) begin
                pipe_q[i]      <= '0;
                pipe_user_q[i] <= '0;
            end
            outstanding_q <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            pipe_q[0]      <= pipe_in;
            pipe_user_q[0] <= q_user_i;
            for (int i = 1; i < SramLatency; i++) begin
                pipe_q[i]      <= pipe_q[i-1];
                pipe_user_q[i] <= pipe_user_q[i-1];
            end
            case ({accept, pop})
                2'b10:   outstanding_q <= outstanding_q + CntWidth'(1);
                2'b01:   outstanding_q <= outstanding_q - CntWidth'(1);
                default: outstanding_q <= outstanding_q;
            endcase
            case ({store, fifo_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CntWidth'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CntWidth'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
            if (store)
                wr_ptr_q <= (wr_ptr_q == PtrWidth'(RspFifoDepth - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
            if (fifo_pop)
                rd_ptr_q <= (rd_ptr_q == PtrWidth'(RspFifoDepth - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (store) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_user_q[wr_ptr_q] <= pipe_user_q[SramLatency-1];
            fifo_err_q[wr_ptr_q]  <= exit_e.error;
        end
    end

endmodule

// File: tb/tb_spatz_spm_responder.sv
// Scoreboard bench for spatz_spm_responder with a behavioural 1-cycle SRAM.
// AMO scenarios are exercised when SPATZ_SPM_AMO_EN is defined, error AMOs otherwise.
module tb_spatz_spm_responder;
    import spatz_spm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        q_valid_i, q_ready_o, q_write_i;
    logic [15:0] q_addr_i;
    logic [3:0]  q_amo_i, q_strb_i;
    logic [31:0] q_data_i;
    logic [7:0]  q_user_i;
    logic        p_valid_o, p_ready_i, p_error_o;
    logic [31:0] p_data_o;
    logic [7:0]  p_user_o;
    logic        sram_req_o, sram_we_o;
    logic [13:0] sram_addr_o;
    logic [31:0] sram_wdata_o, sram_rdata_i;
    logic [3:0]  sram_be_o;

    always #5 clk = ~clk;

    spatz_spm_responder #(
        .AddrWidth(16), .DataWidth(32), .UserWidth(8), .SramLatency(1), .RspFifoDepth(2)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .q_valid_i(q_valid_i), .q_ready_o(q_ready_o), .q_addr_i(q_addr_i),
        .q_write_i(q_write_i), .q_amo_i(q_amo_i), .q_data_i(q_data_i),
        .q_strb_i(q_strb_i), .q_user_i(q_user_i),
        .p_valid_o(p_valid_o), .p_ready_i(p_ready_i), .p_data_o(p_data_o),
        .p_user_o(p_user_o), .p_error_o(p_error_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
    );

    // SRAM model with a preload port used during reset
    logic [31:0] mem [256];
    logic [31:0] rdata_q;
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;
    int          cyc = 0;
    int          n_req = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_req_o) n_req <= n_req + 1;
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be_o[b]) mem[sram_addr_o[7:0]][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
            end else begin
                rdata_q <= mem[sram_addr_o[7:0]];
            end
        end
    end
    assign sram_rdata_i = rdata_q;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  user;
        logic        err;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] shadow [256];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [13:0] last_addr;
    logic        last_req;
    int          acc_cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

`ifdef SPATZ_SPM_AMO_EN
    function automatic logic [31:0] amo_ref(input logic [3:0] op, input logic [31:0] old,
                                            input logic [31:0] opnd, input logic [3:0] strb);
        logic [31:0] r, m;
        case (op)
            4'd1: r = opnd;
            4'd2: r = old + opnd;
            4'd3: r = old & opnd;
            4'd4: r = old | opnd;
            4'd5: r = old ^ opnd;
            4'd6: r = ($signed(old) > $signed(opnd)) ? old : opnd;
            4'd7: r = (old > opnd) ? old : opnd;
            4'd8: r = ($signed(old) < $signed(opnd)) ? old : opnd;
            default: r = (old < opnd) ? old : opnd;
        endcase
        m = old;
        for (int b = 0; b < 4; b++) if (strb[b]) m[b*8 +: 8] = r[b*8 +: 8];
        return m;
    endfunction
`endif

    // Drive one request, wait (bounded) for acceptance, record the expected response
    task automatic send(input logic [15:0] addr, input logic wr, input logic [3:0] amo,
                        input logic [31:0] data, input logic [3:0] strb, input logic [7:0] user);
        int          budget;
        exp_t        e;
        logic [7:0]  idx;
        @(negedge clk);
        q_valid_i = 1'b1; q_addr_i = addr; q_write_i = wr; q_amo_i = amo;
        q_data_i = data; q_strb_i = strb; q_user_i = user;
        budget = 0;
        #1;
        while (!q_ready_o && budget < 50) begin
            @(negedge clk); #1; budget++;
        end
        if (!q_ready_o) begin
            check("accept_timeout", 64'd0, 64'd1);
            q_valid_i = 1'b0;
            return;
        end
        last_addr = sram_addr_o;
        last_req  = sram_req_o;
        acc_cyc   = cyc;
        idx = addr[9:2];
        e.user = user; e.err = 1'b0; e.data = 32'h0;
        if (amo != 4'd0) begin
`ifdef SPATZ_SPM_AMO_EN
            if (amo >= 4'd1 && amo <= 4'd9) begin
                e.data = shadow[idx];
                shadow[idx] = amo_ref(amo, shadow[idx], data, strb);
            end else e.err = 1'b1;
`else
            e.err = 1'b1;
`endif
        end else if (wr) begin
            for (int b = 0; b < 4; b++) if (strb[b]) shadow[idx][b*8 +: 8] = data[b*8 +: 8];
        end else begin
            e.data = shadow[idx];
        end
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        q_valid_i = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 100) begin
            @(negedge clk); b++;
        end
        repeat (2) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Response monitor: pops the scoreboard on every completed p-channel handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst_i && p_valid_o && p_ready_i) begin
                if (exp_q.size() == 0) check("unexpected_rsp", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check("rsp_data", 64'(p_data_o), 64'(e.data));
                    check("rsp_user", 64'(p_user_o), 64'(e.user));
                    check("rsp_err",  64'(p_error_o), 64'(e.err));
                end
            end
        end
    end

    initial begin
        int c0, n0;
        rst_i = 1'b1; q_valid_i = 1'b0; q_addr_i = '0; q_write_i = 1'b0; q_amo_i = '0;
        q_data_i = '0; q_strb_i = '0; q_user_i = '0; p_ready_i = 1'b1;
        pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        for (int i = 0; i < 256; i++) shadow[i] = 32'h0;

        @(negedge clk); #1;
        check("rst_q_ready", 64'(q_ready_o), 64'd0);
        check("rst_p_valid", 64'(p_valid_o), 64'd0);
        check("rst_sram_req", 64'(sram_req_o), 64'd0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pre_en = 1'b1; pre_idx = 8'h10 + 8'(i);
            pre_val = (i == 0) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h111;
            shadow[pre_idx] = pre_val;
        end
        @(negedge clk); pre_en = 1'b0;
        @(negedge clk); rst_i = 1'b0; #1;
        check("post_rst_q_ready", 64'(q_ready_o), 64'd1);
        check("post_rst_p_valid", 64'(p_valid_o), 64'd0);

        // Single read, one-cycle latency
        send(16'h0040, 1'b0, 4'd0, 32'h0, 4'hF, 8'h5A);
        check("rd_sram_addr", 64'(last_addr), 64'h10);
        check("rd_sram_req", 64'(last_req), 64'd1);
        idle(); #1;
        check("rd_latency_valid", 64'(p_valid_o), 64'd1);
        check("rd_latency_data", 64'(p_data_o), 64'hDEADBEEF);
        drain();

        // Four writes then four reads back to back
        for (int i = 0; i < 8; i++) begin
            send(16'h0080 + 16'((i % 4) * 4), (i < 4), 4'd0, 32'hC0DE_0000 + 32'(i), 4'hF, 8'(8'h20 + i));
            if (i == 0) c0 = acc_cyc;
        end
        check("b2b_cycles", 64'(acc_cyc - c0), 64'd7);
        idle(); drain();

        // Partial strobe write
        send(16'h0100, 1'b1, 4'd0, 32'hAAAAAAAA, 4'hF, 8'h30);
        send(16'h0100, 1'b1, 4'd0, 32'h11223344, 4'b0101, 8'h31);
        send(16'h0100, 1'b0, 4'd0, 32'h0, 4'hF, 8'h32);
        idle(); drain();
        check("strb_mem", 64'(mem[8'h40]), 64'hAA22AA44);

        // Back-pressure: only RspFifoDepth accepts, held output
        p_ready_i = 1'b0;
        send(16'h0044, 1'b0, 4'd0, 32'h0, 4'hF, 8'h41);
        send(16'h0048, 1'b0, 4'd0, 32'h0, 4'hF, 8'h42);
        @(negedge clk);
        q_valid_i = 1'b1; q_addr_i = 16'h004C; q_write_i = 1'b0; q_user_i = 8'h43;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_q_ready", 64'(q_ready_o), 64'd0);
            check("bp_p_valid", 64'(p_valid_o), 64'd1);
            check("bp_p_data", 64'(p_data_o), 64'(exp_q[0].data));
            @(negedge clk);
        end
        p_ready_i = 1'b1;
        send(16'h004C, 1'b0, 4'd0, 32'h0, 4'hF, 8'h43);
        idle(); drain();

`ifdef SPATZ_SPM_AMO_EN
        send(16'h0200, 1'b1, 4'd0, 32'd5, 4'hF, 8'h50);
        send(16'h0200, 1'b0, AmoAdd, 32'd3, 4'hF, 8'h51);
        idle(); #1;
        check("amo_busy0", 64'(q_ready_o), 64'd0);
        @(negedge clk); #1;
        check("amo_busy1", 64'(q_ready_o), 64'd0);
        @(negedge clk); #1;
        check("amo_done", 64'(q_ready_o), 64'd1);
        send(16'h0200, 1'b0, 4'd0, 32'h0, 4'hF, 8'h52);
        idle(); drain();
        check("amo_add_mem", 64'(mem[8'h80]), 64'd8);
        send(16'h0200, 1'b0, AmoMin, 32'hFFFFFFFF, 4'hF, 8'h53);
        send(16'h0200, 1'b0, 4'd0, 32'h0, 4'hF, 8'h54);
        idle(); drain();
        check("amo_min_mem", 64'(mem[8'h80]), 64'hFFFFFFFF);
`else
        n0 = n_req;
        send(16'h0200, 1'b0, AmoAdd, 32'd3, 4'hF, 8'h51);
        idle(); drain();
        check("amo_off_no_sram", 64'(n_req - n0), 64'd0);
`endif

        // Reset with buffered responses
        p_ready_i = 1'b0;
        send(16'h0040, 1'b0, 4'd0, 32'h0, 4'hF, 8'h61);
        send(16'h0044, 1'b0, 4'd0, 32'h0, 4'hF, 8'h62);
        idle();
        rst_i = 1'b1;
        @(negedge clk); #1;
        check("midrst_p_valid", 64'(p_valid_o), 64'd0);
        check("midrst_q_ready", 64'(q_ready_o), 64'd0);
        exp_q.delete();
        n0 = n_req;
        p_ready_i = 1'b1;
        @(negedge clk); rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("postrst_no_stale", 64'(p_valid_o), 64'd0);
            @(negedge clk);
        end
        check("postrst_no_sram", 64'(n_req - n0), 64'd0);
        send(16'h0040, 1'b0, 4'd0, 32'h0, 4'hF, 8'h63);
        idle(); drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
